regfile_bank: RTL

//  Parametrised multi-register bank; successor to the single 32-bit register in the

---
 rtl/regfile_bank_pkg.sv | 12 +
 rtl/regfile_preload_fsm.sv | 80 ++++++++
 rtl/regfile_bank.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_bank_pkg.sv
// Shared definitions for the register bank: preload sequencer states and byte geometry.
package regfile_bank_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRELOAD = 2'd1,
        ST_DONE    = 2'd2
    } pl_state_e;

endpackage

// File: rtl/regfile_preload_fsm.sv
// Preload sequencer: captures the fill value and walks every index once,
// issuing one full-width write strobe per cycle.
module regfile_preload_fsm
    import regfile_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              aload,
    input  logic [WIDTH-1:0]  adata,
    output logic              busy,
    output logic              done,
    output logic              pl_we,
    output logic [ADDR_W-1:0] pl_idx,
    output logic [WIDTH-1:0]  pl_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    pl_state_e         state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [WIDTH-1:0]  adata_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            adata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (aload) begin
                        state_q <= ST_PRELOAD;
                        adata_q <= adata;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PRELOAD: begin
                    // Index wraps to 0 as the sequencer leaves, so it never points past the array.
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Index 0 still takes a cycle when it is hardwired, it just never writes.
    assign pl_we   = (state_q == ST_PRELOAD) && !((ZERO_REG != 0) && (idx_q == '0));
    assign pl_idx  = idx_q;
    assign pl_data = adata_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: rtl/regfile_bank.sv
// Multi-entry register bank: one byte-enabled write port, two combinational read
// ports with write-through bypass, optional hardwired-zero entry 0, and bulk preload.
module regfile_bank
    import regfile_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int NBYTES  = WIDTH / BYTE_W
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              aload,
    input  logic [WIDTH-1:0]  adata,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [NBYTES-1:0] wr_be,
    output logic              wr_ack,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              busy,
    output logic              done
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  wr_merged_d;
    logic              wr_commit;
    logic              pl_we;
    logic [ADDR_W-1:0] pl_idx;
    logic [WIDTH-1:0]  pl_data;

    regfile_preload_fsm #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG)
    ) u_preload (
        .clk    (clk),
        .areset (areset),
        .aload  (aload),
        .adata  (adata),
        .busy   (busy),
        .done   (done),
        .pl_we  (pl_we),
        .pl_idx (pl_idx),
        .pl_data(pl_data)
    );

    assign wr_ack = wr_en && !busy;

    // Byte-merged image of the write target; feeds both storage and the read bypass.
    for (genvar b = 0; b < NBYTES; b++) begin : g_merge
        assign wr_merged_d[b*BYTE_W +: BYTE_W] = wr_be[b] ? wr_data[b*BYTE_W +: BYTE_W]
                                                          : mem_q[wr_addr][b*BYTE_W +: BYTE_W];
    end

    assign wr_commit = wr_ack && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (pl_we) begin
            mem_q[pl_idx] <= pl_data;
        end else if (wr_commit) begin
            mem_q[wr_addr] <= wr_merged_d;
        end
    end

    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
            rd_data_a = '0;
        end else if (wr_ack && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_merged_d;
        end
    end

    always_comb begin
        rd_data_b = mem_q[rd_addr_b];
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
            rd_data_b = '0;
        end else if (wr_ack && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_merged_d;
        end
    end

endmodule
